// File: rtl/reset_watchdog_pkg.sv
// Shared definitions for the reset watchdog: FSM encoding, kick key bytes
// and the counter-width helper.
package reset_watchdog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WARN  = 2'd2,
    ST_FIRE  = 2'd3
  } wd_state_e;

  localparam logic [7:0] KEY_FIRST  = 8'hA5;
  localparam logic [7:0] KEY_SECOND = 8'h5A;

  // floor(log2(cycles)) + 1 bits: just enough to hold the value itself.
  function automatic int count_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/reset_watchdog_if.sv
// Software-facing side of the watchdog: enable/kick inputs and status outputs.
interface reset_watchdog_if;
  logic       enable;
  logic       kick;
  logic [7:0] kick_data;
  logic       int_reset;
  logic       armed;
  logic       warn;
  logic       bad_kick;

  modport master (
    output enable, kick, kick_data,
    input  int_reset, armed, warn, bad_kick
  );

  modport slave (
    input  enable, kick, kick_data,
    output int_reset, armed, warn, bad_kick
  );
endinterface

// File: rtl/watchdog_key_check.sv
// Two-byte kick key sequencer (0xA5 then 0x5A); valid/bad are same-cycle
// strobes so the parent can act on the edge of the completing kick.
module watchdog_key_check
  import reset_watchdog_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       kick,
  input  logic [7:0] kick_data,
  input  logic       clear,
  output logic       valid,
  output logic       bad
);

  logic ptr_q, ptr_d;

  // NOTE: every comb output gets a default first, so no path leaves a latch.
  always_comb begin
    valid = 1'b0;
    bad   = 1'b0;
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = 1'b0;
    end else if (kick) begin
      if (ptr_q && kick_data == KEY_SECOND) begin
        valid = 1'b1;
        ptr_d = 1'b0;
      end else begin
        // A stray 0xA5 is still a wrong byte, but it restarts the sequence.
        bad   = ptr_q || (kick_data != KEY_FIRST);
        ptr_d = (kick_data == KEY_FIRST);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reset_watchdog.sv
// Kick-key watchdog: down-counts from timeout_cycles once enabled and requests
// an internal reset pulse of pulse_cycles when the count runs out.
module reset_watchdog
  import reset_watchdog_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1000000,
  parameter int unsigned warn_cycles    = 65536,
  parameter int unsigned pulse_cycles   = 4
) (
  input  logic             clk,
  input  logic             reset,
  reset_watchdog_if.slave  wd
);

  localparam int CNT_W   = count_width(timeout_cycles);
  localparam int PULSE_W = count_width(pulse_cycles);

  localparam logic [CNT_W-1:0]   TIMEOUT    = CNT_W'(timeout_cycles);
  localparam logic [CNT_W-1:0]   WARN_AT    = CNT_W'(warn_cycles);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(pulse_cycles - 1);

  wd_state_e          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic               int_reset_q, int_reset_d;
  logic               armed_q, armed_d;
  logic               warn_q, warn_d;
  logic               bad_kick_q, bad_kick_d;

  logic live, key_valid, key_bad;

  // Kicks only count while the watchdog is running and still enabled.
  assign live = (state_q == ST_ARMED || state_q == ST_WARN) && wd.enable;

  watchdog_key_check u_key_check (
    .clk       (clk),
    .reset     (reset),
    .kick      (wd.kick),
    .kick_data (wd.kick_data),
    .clear     (!live),
    .valid     (key_valid),
    .bad       (key_bad)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      pulse_q     <= '0;
      int_reset_q <= 1'b0;
      armed_q     <= 1'b0;
      warn_q      <= 1'b0;
      bad_kick_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pulse_q     <= pulse_d;
      int_reset_q <= int_reset_d;
      armed_q     <= armed_d;
      warn_q      <= warn_d;
      bad_kick_q  <= bad_kick_d;
    end
  end

  // NOTE: combinational blocks use blocking '=' so count_d can be reused below.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = pulse_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wd.enable) begin
          state_d = ST_ARMED;
          count_d = TIMEOUT;
        end
      end
      ST_ARMED, ST_WARN: begin
        if (!wd.enable) begin
          state_d = ST_IDLE;
        end else if (key_valid) begin
          state_d = ST_ARMED;
          count_d = TIMEOUT;
        end else if (count_q == '0) begin
          state_d = ST_FIRE;
          pulse_d = PULSE_LAST;
        end else begin
          count_d = count_q - 1'b1;
          if (count_d <= WARN_AT) state_d = ST_WARN;
        end
      end
      ST_FIRE: begin
        if (pulse_q == '0) state_d = ST_IDLE;
        else               pulse_d = pulse_q - 1'b1;
      end
    endcase
  end

  always_comb begin
    armed_d     = (state_d == ST_ARMED) || (state_d == ST_WARN);
    warn_d      = (state_d == ST_WARN);
    int_reset_d = (state_d == ST_FIRE);
    bad_kick_d  = key_bad;
  end

  assign wd.int_reset = int_reset_q;
  assign wd.armed     = armed_q;
  assign wd.warn      = warn_q;
  assign wd.bad_kick  = bad_kick_q;

endmodule

// File: tb/tb_reset_watchdog.sv
// Directed scenarios followed by random enable/kick/reset traffic, all checked
// against a timestamp-based reference model of the watchdog.
module tb_reset_watchdog;

  localparam int T = 100;
  localparam int W = 20;
  localparam int P = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reset_watchdog_if wd_if ();

  reset_watchdog #(
    .timeout_cycles (T),
    .warn_cycles    (W),
    .pulse_cycles   (P)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wd    (wd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the edge number of the last (re)load, the edge FIRE
  // began, and whether the first key byte has been seen.
  int n;
  int armed_at;
  int fire_start;
  bit half;
  bit exp_bad;

  function automatic void model_edge(input bit rst, input bit en, input bit k,
                                     input logic [7:0] d);
    bit valid;
    exp_bad = 1'b0;
    valid   = k && half && (d == 8'h5A);
    if (rst) begin
      armed_at = -1; fire_start = -1; half = 1'b0;
    end else if (fire_start >= 0) begin
      if (n - fire_start >= P) fire_start = -1;
      half = 1'b0;
    end else if (armed_at < 0) begin
      if (en) armed_at = n;
      half = 1'b0;
    end else if (!en) begin
      armed_at = -1; half = 1'b0;
    end else begin
      if (valid) begin
        half = 1'b0;
      end else if (k) begin
        exp_bad = !(d == 8'hA5 && !half);
        half    = (d == 8'hA5);
      end
      if (valid) armed_at = n;
      else if (n - 1 - armed_at == T) begin
        armed_at = -1; fire_start = n;
      end
    end
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit k, input logic [7:0] d);
    bit exp_armed, exp_warn, exp_int;
    reset            = rst;
    wd_if.enable     = en;
    wd_if.kick       = k;
    wd_if.kick_data  = d;
    @(posedge clk);
    n++;
    model_edge(rst, en, k, d);
    exp_armed = (armed_at >= 0);
    exp_warn  = (armed_at >= 0) && (T - (n - armed_at) <= W);
    exp_int   = (fire_start >= 0);
    #1;
    check_bit("armed",     wd_if.armed,     exp_armed);
    check_bit("warn",      wd_if.warn,      exp_warn);
    check_bit("int_reset", wd_if.int_reset, exp_int);
    check_bit("bad_kick",  wd_if.bad_kick,  exp_bad);
  endtask

  task automatic idle(input int cycles, input bit en);
    for (int i = 0; i < cycles; i++) step(1'b0, en, 1'b0, 8'h00);
  endtask

  // Runs with enable high until int_reset rises; returns edges since arm_edge.
  task automatic measure_rise(input int arm_edge, output int rise);
    rise = -1;
    for (int i = 0; i < 3 * T && rise < 0; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      if (wd_if.int_reset === 1'b1) rise = n - arm_edge;
    end
  endtask

  int arm_edge;
  int rise;
  int kick_div;
  int pick;
  logic [7:0] rbyte;

  initial begin
    checks = 0; errors = 0; n = 0;
    armed_at = -1; fire_start = -1; half = 1'b0; exp_bad = 1'b0;
    reset = 1'b1; wd_if.enable = 1'b0; wd_if.kick = 1'b0; wd_if.kick_data = 8'h00;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);

    // Free-running expiry: armed at edge 1, int_reset from edge T+1.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    arm_edge = n;
    check_bit("armed_edge1", wd_if.armed, 1'b1);
    measure_rise(arm_edge, rise);
    check_int("expiry_edge", rise, T + 1);
    idle(12, 1'b1);

    // Valid kick at count 50/40 reloads; no warn or expiry afterwards.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(50, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    idle(9, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    idle(T - W - 2, 1'b1);
    check_bit("reload_no_warn", wd_if.warn, 1'b0);

    // Wrong second byte: bad_kick pulse, expiry time unchanged.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    arm_edge = n;
    idle(30, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h33);
    check_bit("bad_kick_pulse", wd_if.bad_kick, 1'b1);
    measure_rise(arm_edge, rise);
    check_int("bad_kick_expiry", rise, T + 1);

    // Key completing on the count==0 cycle wins over expiry.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(50, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    idle(T - 51, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    check_bit("zero_kick_no_fire", wd_if.int_reset, 1'b0);
    idle(20, 1'b1);

    // Enable drop in WARN returns to IDLE; kicks in IDLE are ignored.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(T - W + 5, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'hA5);
    idle(5, 1'b0);

    // Reset during the second FIRE cycle.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(T + 2, 1'b1);
    check_bit("fire_second", wd_if.int_reset, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check_bit("fire_reset", wd_if.int_reset, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Random traffic with alternating dense and sparse kicking.
    for (int i = 0; i < 4000; i++) begin
      kick_div = ((i / 500) % 2 == 0) ? 6 : 80;
      pick = $urandom_range(0, 3);
      rbyte = (pick < 2) ? 8'hA5 : (pick == 2) ? 8'h5A : 8'($urandom_range(0, 255));
      step($urandom_range(0, 999) == 0, $urandom_range(0, 59) != 0,
           $urandom_range(0, kick_div - 1) == 0, rbyte);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_watchdog.md
RESET_WATCHDOG -- requirements
Module: reset_watchdog

Interface
REQ-001 SHALL have parameter timeout_cycles, default 1000000, meaning cycles from reload to expiry.
REQ-002 SHALL have parameter warn_cycles, default 65536, meaning remaining-count threshold for warn; it must be less than timeout_cycles.
REQ-003 SHALL have parameter pulse_cycles, default 4, meaning int_reset pulse length in cycles; it must be at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: level; arms the watchdog while high.
REQ-007 SHALL have port kick, input, 1 bit: single-cycle strobe that qualifies kick_data.
REQ-008 SHALL have port kick_data, input, 8 bits: kick key byte.
REQ-009 SHALL have port int_reset, output, 1 bit: registered reset request to the reset generator's int_reset input.
REQ-010 SHALL have port armed, output, 1 bit: registered; high in ARMED or WARN.
REQ-011 SHALL have port warn, output, 1 bit: registered; high in WARN.
REQ-012 SHALL have port bad_kick, output, 1 bit: registered single-cycle pulse on a wrong key.

Function
REQ-013 SHALL implement states IDLE, ARMED, WARN and FIRE.
REQ-014 SHALL size the down-counter as floor(log2(timeout_cycles))+1 bits, with no wrap below 0.
REQ-015 SHALL, in IDLE with enable high, load count=timeout_cycles and go to ARMED on the next edge.
REQ-016 SHALL, in ARMED/WARN, decrement count by 1 per cycle.
REQ-017 SHALL go from ARMED to WARN on the edge where count becomes <= warn_cycles.
REQ-018 SHALL, at the edge after count==0, go to FIRE and set int_reset=1; int_reset therefore rises timeout_cycles+1 edges after a reload.
REQ-019 SHALL hold int_reset high for exactly pulse_cycles cycles in FIRE, then go to IDLE with int_reset=0.
REQ-020 SHALL treat a valid kick as two kicks, 0xA5 then 0x5A, with any number of idle cycles between them.
REQ-021 SHALL, on a valid kick in ARMED/WARN, reload count=timeout_cycles, go to ARMED and clear warn on the same edge as the 0x5A kick.
REQ-022 SHALL, on a wrong byte in ARMED/WARN, pulse bad_kick for 1 cycle, clear the key pointer and leave count unchanged; a wrong byte equal to 0xA5 restarts the sequence as a first byte.
REQ-023 SHALL ignore kicks in IDLE and FIRE: no bad_kick, key pointer held at 0.
REQ-024 SHALL, when enable goes low in ARMED/WARN, go to IDLE on the next edge and clear the key pointer.
REQ-025 SHALL ignore enable in FIRE.
REQ-026 SHALL resolve simultaneous events as follows: a valid 0x5A kick on the cycle count==0 wins (reload, no FIRE); enable low together with a kick gives IDLE.

Reset
REQ-027 SHALL, on reset, set state=IDLE, count=0, key pointer=0, int_reset=0, armed=0, warn=0 and bad_kick=0 on the next edge.
REQ-028 SHALL, on reset during FIRE, deassert int_reset on the next edge and discard the remaining pulse count.
REQ-029 SHALL start with no auto-arm after reset: enable must be sampled high in IDLE.

Structure
REQ-030 SHALL place the key constants (0xA5, 0x5A) and the state encoding in the shared core package.
REQ-031 SHALL implement the two-byte key sequencer as sub-module watchdog_key_check (inputs kick, kick_data, clear; outputs valid, bad).
REQ-032 SHALL keep the counter, FSM and output registers in reset_watchdog.

Verification (timeout_cycles=100, warn_cycles=20, pulse_cycles=4)
REQ-033 SHALL cover: enable high, no kicks -> armed at edge 1, warn after count reaches 20, int_reset high edges 102-105, then IDLE.
REQ-034 SHALL cover: kick 0xA5 at count 50 and 0x5A at count 40 -> count reloads to 100, no warn, no int_reset.
REQ-035 SHALL cover: kick 0xA5 then 0x33 -> bad_kick 1 cycle, count unaffected, expiry at the original time.
REQ-036 SHALL cover: 0x5A kick completing on the count==0 cycle -> reload, int_reset stays 0.
REQ-037 SHALL cover: enable drop in WARN -> IDLE, warn=0, no int_reset; kicks in IDLE give no bad_kick.
REQ-038 SHALL cover: reset asserted on the 2nd FIRE cycle -> int_reset=0 next edge, all outputs at reset values.
